// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan sequencer.
package seg_scan_pkg;

  // Scan direction encodings for the dir input
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Anode level that turns a digit off (anodes are active-low)
  localparam logic ANODE_OFF = 1'b1;

  // Minimum select width able to address n scan positions
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Masked priority search for the next scan position, both directions.
// Up: smallest enabled index above sel, else wrap to the lowest enabled one.
// Down: largest enabled index below sel, else wrap to the highest enabled one.
// With no enabled position, next_sel holds sel and wrap stays low.
module scan_next_sel
  import seg_scan_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int SEL_W  = 3
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [DIGITS-1:0] digit_mask,
  input  logic              dir,
  output logic [SEL_W-1:0]  next_sel,
  output logic              wrap,
  output logic              none_enabled
);

  int               cur;
  logic [SEL_W-1:0] lo, hi, gt, lt;
  logic             have_gt, have_lt;

  // Gather the lowest/highest enabled index and the nearest neighbours of sel
  always_comb begin
    cur     = 32'(sel);
    lo      = '0;
    hi      = '0;
    gt      = '0;
    lt      = '0;
    have_gt = 1'b0;
    have_lt = 1'b0;
    // Descending walk: last hit is the smallest qualifying index
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i]) begin
        lo = SEL_W'(i);
        if (i > cur) begin
          gt      = SEL_W'(i);
          have_gt = 1'b1;
        end
      end
    end
    // Ascending walk: last hit is the largest qualifying index
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_mask[i]) begin
        hi = SEL_W'(i);
        if (i < cur) begin
          lt      = SEL_W'(i);
          have_lt = 1'b1;
        end
      end
    end
  end

  // Pick the neighbour for the requested direction, or wrap
  always_comb begin
    none_enabled = (digit_mask == '0);
    next_sel     = sel;
    wrap         = 1'b0;
    if (!none_enabled) begin
      case (dir)
        DIR_UP: begin
          next_sel = have_gt ? gt : lo;
          wrap     = !have_gt;
        end
        DIR_DOWN: begin
          next_sel = have_lt ? lt : hi;
          wrap     = !have_lt;
        end
        default: begin
          next_sel = sel;
          wrap     = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/digit_scan_counter.sv
// Prescaled scan sequencer for a multiplexed seven-segment display.
// Drives the digit-mux select, active-low one-hot anodes, and slot/frame pulses.
// Optional feature macro: SCAN_BLANK_EN -- blanks the anodes for the first
// BLANK_CYCLES clocks of every slot to suppress ghosting between digits.
module digit_scan_counter
  import seg_scan_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SEL_W        = 3,
  parameter int PRESCALE     = 250000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic [DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]  sel,
  output logic [DIGITS-1:0] an,
  output logic              tick,
  output logic              frame
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Elaboration-time parameter sanity checks
  if (SEL_W < sel_width(DIGITS)) begin : g_bad_sel_w
    $error("SEL_W too narrow for DIGITS");
  end
`ifdef SCAN_BLANK_EN
  if (BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
    $error("BLANK_CYCLES must be below PRESCALE");
  end
`else
  if (BLANK_CYCLES < 0) begin : g_bad_blank
    $error("BLANK_CYCLES must not be negative");
  end
`endif

  logic [PS_W-1:0]   count, count_next;
  logic              slot_end;
  logic [SEL_W-1:0]  next_sel;
  logic              wrap, none_enabled;
  logic [DIGITS-1:0] hot, an_next;

  assign slot_end = en && (count == PS_LAST);

  // Prescaler advance: wraps at the end of a slot, frozen while disabled
  always_comb begin
    count_next = count;
    if (en) begin
      count_next = slot_end ? '0 : count + 1'b1;
    end
  end

  scan_next_sel #(
    .DIGITS(DIGITS),
    .SEL_W (SEL_W)
  ) u_next (
    .sel         (sel),
    .digit_mask  (digit_mask),
    .dir         (dir),
    .next_sel    (next_sel),
    .wrap        (wrap),
    .none_enabled(none_enabled)
  );

  // One-hot decode of the current position
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hot
    assign hot[gi] = (sel == SEL_W'(gi));
  end

  // Anode value for the next cycle; blanking keys off the upcoming prescaler
  // value so the dark window lines up with the first cycles of the new slot
  always_comb begin
    an_next = ~(hot & digit_mask);
`ifdef SCAN_BLANK_EN
    if (int'(count_next) < BLANK_CYCLES) begin
      an_next = {DIGITS{ANODE_OFF}};
    end
`endif
  end

  // Prescaler, position and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sel   <= '0;
      tick  <= 1'b0;
      frame <= 1'b0;
    end else begin
      count <= count_next;
      tick  <= slot_end;
      frame <= slot_end && wrap && !none_enabled;
      if (slot_end) begin
        sel <= next_sel;
      end
    end
  end

  // Anode register; reset turns every digit off without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an <= {DIGITS{ANODE_OFF}};
    end else begin
      an <= an_next;
    end
  end

endmodule

// File: tb/tb_digit_scan_counter.sv
// Self-checking bench for digit_scan_counter (DIGITS=8, PRESCALE=4).
// Directed vector table, randomized stimulus against a reference model,
// and an asynchronous mid-slot reset sequence. Honours SCAN_BLANK_EN.
module tb_digit_scan_counter;

  localparam int P     = 4;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       dir = 1'b0;
  logic [7:0] mask = 8'hFF;
  logic [2:0] sel;
  logic [7:0] an;
  logic       tick, frame;

  int tests = 0;
  int fails = 0;

  digit_scan_counter #(
    .DIGITS(8), .SEL_W(3), .PRESCALE(P), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .digit_mask(mask),
    .sel(sel), .an(an), .tick(tick), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference next-position rule: step around the ring one position at a
  // time in the scan direction; crossing past the ends counts as a wrap.
  // Returns {wrap, position}.
  function automatic logic [3:0] next_pos(input logic [2:0] cur, input logic [7:0] m, input logic d);
    int c;
    int cand;
    c = int'(cur);
    if (m == 8'h00) return {1'b0, cur};
    for (int k = 1; k <= 8; k++) begin
      cand = d ? (c - k + 8) % 8 : (c + k) % 8;
      if (m[cand]) begin
        if (d) return {(cand >= c), 3'(cand)};
        else   return {(cand <= c), 3'(cand)};
      end
    end
    return {1'b0, cur};
  endfunction

  // ---------------- reference model ----------------
  int         m_cnt, m_cnt_next;
  logic [2:0] m_sel;
  logic [7:0] m_an, m_an_next;
  logic       m_tick, m_frame;
  logic [3:0] m_nx;
  logic       m_adv;

  assign m_nx  = next_pos(m_sel, mask, dir);
  assign m_adv = en && (m_cnt == P - 1);

  // Model combinational helpers
  always_comb begin
    m_cnt_next = en ? ((m_cnt == P - 1) ? 0 : m_cnt + 1) : m_cnt;
    m_an_next  = ~((8'd1 << m_sel) & mask);
`ifdef SCAN_BLANK_EN
    if (m_cnt_next < BLANK) m_an_next = 8'hFF;
`endif
  end

  // Model state update
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_sel <= 3'd0; m_an <= 8'hFF; m_tick <= 1'b0; m_frame <= 1'b0;
    end else begin
      m_cnt   <= m_cnt_next;
      m_an    <= m_an_next;
      m_tick  <= m_adv;
      m_frame <= m_adv && m_nx[3];
      if (m_adv) m_sel <= m_nx[2:0];
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("model_sel", 32'(sel), 32'(m_sel));
      check("model_an", 32'(an), 32'(m_an));
      check("model_tick", 32'(tick), 32'(m_tick));
      check("model_frame", 32'(frame), 32'(m_frame));
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       en;
    logic       dir;
    logic [7:0] mask;
    int         cycles;
    logic [2:0] sel;
    logic [7:0] an;
    logic       tick;
    logic       frame;
  } vec_t;

  vec_t vecs[25];

  initial begin
    // up scan, all digits
    vecs[0]  = '{1'b1, 1'b0, 8'hFF, 1,  3'd0, 8'hFE, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'hFF, 3,  3'd1, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'hFF, 1,  3'd1, 8'hFD, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'hFF, 23, 3'd7, 8'hBF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'hFF, 4,  3'd0, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'hFF, 1,  3'd0, 8'hFE, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'hFF, 7,  3'd2, 8'hFD, 1'b1, 1'b0};
    // down scan from 2
    vecs[7]  = '{1'b1, 1'b1, 8'hFF, 4,  3'd1, 8'hFB, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'hFF, 4,  3'd0, 8'hFD, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'hFF, 4,  3'd7, 8'hFE, 1'b1, 1'b1};
    // sparse mask 0010_0101, up
    vecs[10] = '{1'b1, 1'b0, 8'h25, 4,  3'd0, 8'hFF, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h25, 4,  3'd2, 8'hFE, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h25, 1,  3'd2, 8'hFB, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h21, 1,  3'd2, 8'hFF, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h21, 2,  3'd5, 8'hFF, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'h21, 4,  3'd0, 8'hDF, 1'b1, 1'b1};
    // everything masked, then a single position
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1,  3'd0, 8'hFF, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 3,  3'd0, 8'hFF, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 8'h00, 4,  3'd0, 8'hFF, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 8'h08, 4,  3'd3, 8'hFF, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 8'h08, 4,  3'd3, 8'hF7, 1'b1, 1'b1};
    // freeze at prescaler value 2, then resume
    vecs[21] = '{1'b1, 1'b0, 8'h08, 2,  3'd3, 8'hF7, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 8'h08, 10, 3'd3, 8'hF7, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 8'h08, 1,  3'd3, 8'hF7, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 8'h08, 1,  3'd3, 8'hF7, 1'b1, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_an", 32'(an), 32'hFF);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_frame", 32'(frame), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      en   = vecs[i].en;
      dir  = vecs[i].dir;
      mask = vecs[i].mask;
      repeat (vecs[i].cycles) @(posedge clk);
      @(negedge clk);
      $display("[TB] vec %0d: en=%0b dir=%0b mask=%02h sel=%0d an=%02h tick=%0b frame=%0b",
               i, en, dir, mask, sel, an, tick, frame);
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
`ifndef SCAN_BLANK_EN
      check($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].an));
`endif
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tick));
      check($sformatf("vec%0d_frame", i), 32'(frame), 32'(vecs[i].frame));
    end

    // randomized stimulus; the model checker compares every cycle
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0:       mask = 8'h00;
          1:       mask = 8'd1 << $urandom_range(0, 7);
          2:       mask = 8'($urandom);
          default: mask = 8'hFF;
        endcase
      end
      @(negedge clk);
    end

    // asynchronous reset mid-slot, between clock edges
    en = 1'b1; dir = 1'b0; mask = 8'hFF;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] async reset: sel=%0d an=%02h tick=%0b", sel, an, tick);
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_an", 32'(an), 32'hFF);
    check("async_rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (P) @(posedge clk);
    @(negedge clk);
    check("post_rst_first_tick", 32'(tick), 32'd1);
    check("post_rst_sel", 32'(sel), 32'd1);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/digit_scan_counter.md
# digit_scan_counter

Parameterised scan sequencer for the multiplexed seven-segment display. It replaces the fixed free-running 3-bit select counter and its separate 400 Hz clock with a prescaled counter that runs on the system clock. It adds a configurable digit count, up/down scan direction, per-digit masking with skip, and active-low one-hot anode drive. It also provides slot and frame pulses. It sits between the system clock and the digit-data mux and anode pins of the display block.

## Interface
- DIGITS, 8, number of scan positions; legal range 2..16
- SEL_W, 3, width of `sel`; must be ≥ clog2(DIGITS)
- PRESCALE, 250000, system clocks per scan slot; 100 MHz / 250000 = 400 Hz; legal minimum 1
- BLANK_CYCLES, 1000, blanking length at the start of each slot; used only with SCAN_BLANK_EN; must be < PRESCALE
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  scan enable; low freezes the prescaler and position
- dir  in  1  scan direction: 0 = up, 1 = down
- digit_mask  in  DIGITS  1 = position active; masked positions are skipped
- sel  out  SEL_W  current position; drives the digit-data mux select
- an  out  DIGITS  registered anode enables, one-hot, active-low
- tick  out  1  one-cycle pulse on each slot advance
- frame  out  1  one-cycle pulse when the scan wraps

## Operation
- Reset values: prescaler 0, `sel` 0, `an` all ones (all off), `tick` 0, `frame` 0.
- The prescaler counts 0..PRESCALE-1 while `en`=1. At PRESCALE-1 it returns to 0, `sel` loads the next position, and `tick` asserts.
- Next position, up scan: the smallest enabled index greater than `sel`. If none exists, the scan wraps to the smallest enabled index and `frame` asserts.
- Next position, down scan: the largest enabled index less than `sel`. If none exists, the scan wraps to the largest enabled index and `frame` asserts.
- Single enabled position: `sel` stays on that position and `frame` pulses on every tick.
- All positions masked: `sel` holds, `an` is all ones, `tick` still pulses, `frame` stays 0.
- `an` register: each cycle it loads ~(onehot(sel) & digit_mask). A masked current `sel` blanks on the next cycle, and the scan advances normally at the next tick.
- `en`=0: prescaler and `sel` hold; `an` keeps driving the current digit; `tick` and `frame` stay 0. Counting resumes from the held prescaler value.
- `dir` and `digit_mask` are sampled at each tick. Changes between ticks have no effect on `sel`.
- After reset, `sel` is 0 even if position 0 is masked. The first tick moves `sel` to a legal position.

## Timing
- `tick` and `frame` are registered and coincide with the first cycle of the new `sel` value.
- `an` lags `sel` by one cycle. `sel` and `an` are both glitch-free register outputs.
- With the scan enabled and not frozen, slot period is exactly PRESCALE cycles. With PRESCALE=1, `tick` is high on every enabled cycle.
- Asserting `rst` clears all state immediately, mid-slot included; `an` goes all ones without waiting for a clock edge. After release, the first prescaler increment occurs on the first rising edge.

## Configuration
- SCAN_BLANK_EN defined:
  - `an` is forced all ones while the prescaler value is < BLANK_CYCLES in each slot, suppressing ghosting between digits.
  - `an` is held off while the blank condition is true, even if `en`=0.
- SCAN_BLANK_EN undefined:
  - No blanking logic is built; BLANK_CYCLES is ignored.

## Structure
- Shared package `seg_scan_pkg`:
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1
  - ANODE_OFF level = 1'b1
  - width helper function for SEL_W checking
- Sub-module `scan_next_sel`, combinational:
  - inputs: `sel`, `digit_mask`, `dir`
  - outputs: `next_sel`, `wrap`, `none_enabled`
  - implements the masked priority search in both directions
- Top level holds the prescaler, position, anode and pulse registers.

## Test plan
Bench parameters: DIGITS=8, PRESCALE=4.
1. Reset, mask=8'hFF, dir=0 -> `sel` steps 0,1,…,7,0 every 4 clocks; `tick` pulses on each step; `frame` pulses only at 7→0; `an` goes 8'hFE, then 8'hFD one slot later.
2. From `sel`=2, set dir=1 -> `sel` steps 2,1,0,7; `frame` pulses only at 0→7.
3. mask=8'b0010_0101, dir=0 -> `sel` cycles 0,2,5,0 with `frame` at 5→0. Clearing bit 2 while `sel`=2 -> `an`=8'hFF next cycle, next tick goes to 5.
4. mask=8'h00 -> `an`=8'hFF, `sel` holds, `tick` every 4 clocks, `frame` 0. Then mask=8'h08 -> `sel`=3 at the next tick and `frame` on every tick.
5. `en`=0 for 10 cycles at prescaler value 2 -> `sel`, `an` and prescaler hold, no pulses. After `en` returns to 1, the advance occurs 2 cycles later.
6. `rst` pulsed between clock edges mid-slot -> `an`=8'hFF and `sel`=0 immediately. With SCAN_BLANK_EN and BLANK_CYCLES=2 -> `an`=8'hFF for the first 2 cycles of each slot, digit driven for the remaining 2.
